// File: rtl/mips_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_uart_pkg
//  Description : Shared types, constants and frame builder for the processor
//                result UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_uart_pkg;

    // Serialiser states for one 8N1 byte
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int BYTES_PER_FRAME = 3;
    localparam int DATA_BITS       = 8;
    localparam int FRAME_RESULT_W  = 17;

    // Element [0] is sent first
    typedef logic [BYTES_PER_FRAME-1:0][DATA_BITS-1:0] frame_t;

    // Split a 17-bit result into its three bytes, most significant first
    function automatic frame_t build_frame(input logic [FRAME_RESULT_W-1:0] value);
        frame_t f;
        f[0] = {7'b0, value[16]};
        f[1] = value[15:8];
        f[2] = value[7:0];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : Single-byte 8N1 serialiser. A start pulse in IDLE, or on the
//                last cycle of the stop bit, loads a new byte with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import mips_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 done_o
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 w_baud_end;

    assign w_baud_end = (baud_q == BAUD_LAST);
    // Last cycle of the stop bit: the parent may chain the next byte here
    assign done_o     = (state_q == STOP) && w_baud_end;
    assign tx_o       = tx_q;

    // State, counters and line register; line idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state: each bit held for CLKS_PER_BIT cycles, data LSB first
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != IDLE) begin
            baud_d = w_baud_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (w_baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (w_baud_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (w_baud_end) begin
                    if (start_i) begin
                        state_d = START;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mips_result_uart_tx
//  Description : Watches the processor result bus and sends each new value as
//                a 3-byte 8N1 frame, with a one-deep pending buffer and a
//                sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_result_uart_tx
    import mips_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int RESULT_W     = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RESULT_W-1:0] result,
    output logic                tx,
    output logic                busy,
    output logic                overrun
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_FRAME - 1);

    logic [RESULT_W-1:0]  last_q, last_d;
    logic [RESULT_W-1:0]  pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    frame_t               frame_q, frame_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic                 w_done;
    logic                 w_frame_end;
    logic                 w_next_byte;
    logic                 w_launch;
    logic [RESULT_W-1:0]  w_launch_val;
    logic [RESULT_W-1:0]  w_cmp;
    frame_t               w_new_frame;
    logic                 w_start;
    logic [DATA_BITS-1:0] w_data;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_start),
        .data_i  (w_data),
        .tx_o    (tx),
        .done_o  (w_done)
    );

    assign busy    = busy_q;
    assign overrun = overrun_q;

    // Frame sequencing and launch decision; a queued value always wins over a fresh one
    always_comb begin
        w_frame_end  = w_done && (byte_idx_q == LAST_BYTE);
        w_next_byte  = w_done && (byte_idx_q != LAST_BYTE);
        w_cmp        = pend_v_q ? pend_q : last_q;
        w_launch     = (!busy_q && (pend_v_q || (result != last_q)))
                     || (w_frame_end && pend_v_q);
        w_launch_val = pend_v_q ? pend_q : result;
        w_new_frame  = build_frame(w_launch_val);
        w_start      = w_launch || w_next_byte;
        w_data       = w_new_frame[0];
        if (!w_launch) begin
            case (byte_idx_q)
                2'd0:    w_data = frame_q[1];
                default: w_data = frame_q[2];
            endcase
        end
    end

    // Capture, pending buffer and overrun next-state
    always_comb begin
        last_d     = last_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        frame_d    = frame_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        if (w_launch) begin
            last_d     = w_launch_val;
            frame_d    = w_new_frame;
            byte_idx_d = '0;
            busy_d     = 1'b1;
            // A change coinciding with the launch refills the freed slot: not an overrun
            if (pend_v_q) begin
                pend_d   = result;
                pend_v_d = (result != pend_q);
            end
        end else begin
            if (w_next_byte) begin
                byte_idx_d = byte_idx_q + 1'b1;
            end
            if (w_frame_end) begin
                byte_idx_d = '0;
                busy_d     = 1'b0;
            end
            if (busy_q && (result != w_cmp)) begin
                pend_d   = result;
                pend_v_d = 1'b1;
                if (pend_v_q) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // Registered state, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            frame_q    <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            frame_q    <= frame_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_result_uart_tx
//  Description : Self-checking bench; a line monitor decodes 8N1 bytes and
//                compares them with a queue of expected bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_result_uart_tx;

    localparam int CPB = 4;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [16:0] result = 17'h1ABCD;
    logic        tx;
    logic        busy;
    logic        overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb [$];

    logic [7:0]  mon_got;
    logic [7:0]  mon_exp;
    logic        mon_stop;
    logic        mon_abort;

    mips_result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .RESULT_W     (17)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .result  (result),
        .tx      (tx),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Line monitor: decode each byte at the first cycle of each bit
    initial begin : line_monitor
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                mon_got   = '0;
                mon_stop  = 1'b0;
                mon_abort = 1'b0;
                for (int b = 0; b < 9; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (reset) begin
                            mon_abort = 1'b1;
                            break;
                        end
                    end
                    if (mon_abort) break;
                    if (b < 8) mon_got[b] = tx;
                    else       mon_stop   = tx;
                end
                if (!mon_abort) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL uart_byte: unexpected byte got=%02h, none expected", mon_got);
                    end else begin
                        mon_exp = sb.pop_front();
                        if (mon_got !== mon_exp || mon_stop !== 1'b1) begin
                            n_err++;
                            $display("FAIL uart_byte: got=%02h stop=%b required=%02h stop=1",
                                     mon_got, mon_stop, mon_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [16:0] v);
        sb.push_back({7'b0, v[16]});
        sb.push_back(v[15:8]);
        sb.push_back(v[7:0]);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        result = 17'h1ABCD;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: tx=%b busy=%b overrun=%b required 1/0/0", tx, busy, overrun);
            end
        end
    endtask

    task automatic test_idle_zero();
        int bad;
        bad    = 0;
        result = 17'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_zero: active cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_single_frame();
        int cnt;
        @(negedge clk);
        result = 17'h1ABCD;
        push_frame(17'h1ABCD);
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL capture_edge: tx=%b busy=%b required tx=0 busy=1", tx, busy);
        end
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
            else break;
        end
        n_cmp++;
        if (cnt != 30 * CPB) begin
            n_err++;
            $display("FAIL single_busy_len: got=%0d required=%0d", cnt, 30 * CPB);
        end
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL single_tx_idle: tx=%b required 1", tx);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL single_drain: bytes left=%0d required 0", sb.size());
        end
    endtask

    task automatic test_pending_overrun();
        int   cnt;
        logic tx120;
        logic tx121;
        tx120 = 1'bx;
        tx121 = 1'bx;
        @(negedge clk);
        result = 17'h0BEEF;
        push_frame(17'h0BEEF);
        @(posedge clk);
        #1;
        cnt = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 10) result = 17'h00012;
            if (k == 20) begin
                result = 17'h00034;
                push_frame(17'h00034);
            end
            if (k == 30 * CPB)     tx120 = tx;
            if (k == 30 * CPB + 1) tx121 = tx;
            if (busy === 1'b1) cnt++;
            else break;
        end
        n_cmp++;
        if (cnt != 60 * CPB) begin
            n_err++;
            $display("FAIL pending_busy_len: got=%0d required=%0d", cnt, 60 * CPB);
        end
        n_cmp++;
        if (tx120 !== 1'b1 || tx121 !== 1'b0) begin
            n_err++;
            $display("FAIL pending_seam: tx@120=%b tx@121=%b required 1 then 0", tx120, tx121);
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: overrun=%b required 1", overrun);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_drain: bytes left=%0d required 0", sb.size());
        end
    endtask

    task automatic test_same_value();
        int cnt;
        int bad;
        @(negedge clk);
        reset  = 1'b1;
        result = 17'h0;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: overrun=%b required 0", overrun);
        end
        @(negedge clk);
        result = 17'h00077;
        push_frame(17'h00077);
        @(posedge clk);
        #1;
        cnt = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 10 || k == 30 || k == 60 || k == 119) result = 17'h00077;
            if (busy === 1'b1) cnt++;
            else break;
        end
        n_cmp++;
        if (cnt != 30 * CPB) begin
            n_err++;
            $display("FAIL same_busy_len: got=%0d required=%0d", cnt, 30 * CPB);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL same_no_pending: extra active cycles=%0d overrun=%b required 0/0", bad, overrun);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL same_drain: bytes left=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        @(negedge clk);
        result = 17'h00005;
        push_frame(17'h00005);
        @(posedge clk);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: tx=%b busy=%b required tx=1 busy=0", tx, busy);
        end
        sb.delete();
        push_frame(17'h00005);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_capture: tx=%b busy=%b required tx=0 busy=1", tx, busy);
        end
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
            else break;
        end
        n_cmp++;
        if (cnt != 30 * CPB) begin
            n_err++;
            $display("FAIL post_reset_busy_len: got=%0d required=%0d", cnt, 30 * CPB);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_drain: bytes left=%0d overrun=%b required 0/0", sb.size(), overrun);
        end
    endtask

    initial begin : main
        test_reset();
        test_idle_zero();
        test_single_frame();
        test_pending_overrun();
        test_same_value();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_result_uart_tx.md
Name: mips_result_uart_tx

Overview:
- Consumer end of the processor's `result` output: watches the 17-bit `result` bus of MIPSProcessor and reports each new value off-chip as a 3-byte UART 8N1 frame.
- Sits beside the processor in the top level and replaces bench-only observation of `result` with a physical serial line.
- Has a one-deep pending buffer, so a value that changes during a transmission is not lost unless it is overwritten again.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit; must be ≥2.
- RESULT_W, 17, width of `result`; the frame layout below is fixed for 17.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- result  input  RESULT_W  processor result bus; synchronous to clk.
- tx  output  1  UART line; idles high.
- busy  output  1  high while a frame is on the line.
- overrun  output  1  sticky; a pending value was overwritten before it could be sent.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - tx=1, busy=0, overrun=0.
  - last_captured=0; pending_valid=0; FSM to IDLE; all counters 0.
- Change detection: compare `result` each rising edge against `cmp`.
  - `cmp` = pending value if pending_valid, else last_captured.
  - No frame is sent for a value equal to the last captured one, so a constant 0 after reset sends nothing.
- Capture when IDLE and result≠last_captured:
  - Load the 3 frame bytes and set last_captured=result.
  - tx goes low (start bit) and busy goes high at that same edge, because tx is registered.
- Frame layout: byte0={7'b0,result[16]}, byte1=result[15:8], byte2=result[7:0].
  - Bytes are sent in order 0, 1, 2, back to back with no idle bits.
  - Each byte: start 0, data LSB first, stop 1; every bit held exactly CLKS_PER_BIT cycles.
  - Frame length: 30*CLKS_PER_BIT cycles from the capture edge.
- FSM: IDLE → START → DATA → STOP.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA bit index 0..7 → STOP.
  - STOP → START of the next byte if byte index<2.
  - STOP of byte2 → IDLE, or directly → START if pending_valid.
- Change during busy (result≠cmp):
  - If the pending slot is empty: latch result, set pending_valid=1.
  - If the pending slot is full: overwrite it and set overrun=1, which stays set until reset.
- Pending launch: at the end edge of byte2's stop bit, if pending_valid:
  - Capture pending into the frame bytes and last_captured; clear pending_valid.
  - tx goes low that same edge; busy stays high with no gap.
  - If result also changes at that edge, the new value becomes the next pending value. This is not an overrun.
- Without pending: busy falls and tx=1 at edge capture+30*CLKS_PER_BIT.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; bit and byte counters wrap to 0 at their ends.
- No combinational path from input to output; tx, busy and overrun are all flops.

Decomposition:
- Package mips_uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Constants BYTES_PER_FRAME=3, DATA_BITS=8.
  - Function build_frame(result) returning the 3 bytes.
- One sub-module, uart_byte_tx: single-byte 8N1 shifter with a start/done handshake, parameterised by CLKS_PER_BIT.
- Top level keeps change detection, the pending buffer, byte sequencing and overrun.

Test Plan:
- Reset held with result=17'h1ABCD → tx=1, busy=0, overrun=0 throughout; no frame.
- Release reset with result=0 held for 200 cycles → tx stays 1, busy stays 0.
- result=17'h1ABCD while IDLE (CLKS_PER_BIT=4):
  - tx falls at the capture edge; bytes decode as 0x01, 0xAB, 0xCD.
  - busy high for exactly 120 cycles, then tx=1.
- During that frame, result→17'h00012 at +10 cycles, then →17'h00034 at +20:
  - overrun=1.
  - A second frame 0x00, 0x00, 0x34 starts exactly 120 cycles after the first capture, with no idle bit.
  - busy is continuous for 240 cycles.
- During a frame, result is set back to the value being sent → no pending frame, overrun stays 0.
- Reset asserted during a DATA bit of byte1:
  - tx=1 and busy=0 asynchronously.
  - After release with result=17'h00005 unchanged, one full frame 0x00, 0x00, 0x05 is sent.
